// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage for the non-pipelined RISC-V core. Owns
//            the program counter, presents a word index to the instruction
//            memory, and captures the returned word into a registered IF
//            output with a valid/ready handshake toward decode. Handles
//            branch/jump redirects and traps on misaligned or out-of-range
//            fetch addresses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   1   rising-edge clock
//   reset            in   1   asynchronous, active-low reset
//   redirect_valid   in   1   branch/jump taken this cycle
//   redirect_target  in  32   byte address of the redirect target
//   imem_addr        out 32   word index into instruction memory (pc_q >> 2)
//   imem_instr       in  32   combinational read data for imem_addr
//   if_valid         out  1   IF output holds a fetched instruction
//   if_ready         in   1   decode accepts the IF output this cycle
//   if_instr         out 32   fetched instruction
//   if_pc            out 32   byte address of if_instr
//   if_pc_plus4      out 32   if_pc + 4 (link value for JAL/JALR)
//   fetch_fault      out  1   sticky misaligned / out-of-range PC flag
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fetch_fault
);

    // First byte address past the end of instruction memory.
    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] ipc_d;
    logic [31:0] ipc4_d;
    logic        fault_d;

    logic        pc_ok;
    logic        out_free;
    logic        fetch_en;

    // ------------------------------------------------------------------------
    // Fetch qualification
    // ------------------------------------------------------------------------
    assign pc_ok    = (pc_q[1:0] == 2'b00) && (pc_q < PC_LIMIT);

    // The output register can take a new word when it is empty or when decode
    // is draining it this very cycle.
    assign out_free = !if_valid || if_ready;

    assign fetch_en = (state_q == ST_RUN) && out_free && !redirect_valid && pc_ok;

    assign imem_addr = {2'b00, pc_q[31:2]};

    // ------------------------------------------------------------------------
    // Next-state and next-datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = if_valid;
        instr_d = if_instr;
        ipc_d   = if_pc;
        ipc4_d  = if_pc_plus4;
        fault_d = fetch_fault;

        case (state_q)
            ST_IDLE: begin
                // One quiet cycle after reset before the first fetch.
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    // Redirect wins over everything: drop whatever is held
                    // (even if decode takes it this cycle, that acceptance
                    // still happens exactly once) and restart at the target.
                    // A bad target is loaded anyway and trapped next edge.
                    valid_d = 1'b0;
                    pc_d    = redirect_target;
                end else if (!pc_ok) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                end else if (fetch_en) begin
                    instr_d = imem_instr;
                    ipc_d   = pc_q;
                    ipc4_d  = pc_q + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end else if (if_valid && if_ready) begin
                    valid_d = 1'b0;
                end
            end

            ST_FAULT: begin
                // Terminal until reset; redirects are ignored here.
                valid_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= 32'd0;
            if_pc       <= 32'd0;
            if_pc_plus4 <= 32'd0;
            fetch_fault <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_valid    <= valid_d;
            if_instr    <= instr_d;
            if_pc       <= ipc_d;
            if_pc_plus4 <= ipc4_d;
            fetch_fault <= fault_d;
        end
    end

endmodule
`default_nettype wire
